rv_timer: RTL and testbench

//  Memory-mapped 32-bit timer/compare peripheral on the rv_core data bus, decoded at ffff0040..ffff005f

---
 rtl/rv_timer_if.sv | 14 +
 rtl/rv_timer.sv | 115 +++++++++++
 tb/tb_rv_timer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_timer_if.sv
// Bus-side signals of the rv_timer peripheral: register access from rv_core plus the irq back to it.
interface rv_timer_if;
    logic [4:0]  adr;
    logic        cs;
    logic        rdy;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr;
    logic        irq;

    modport master (output adr, cs, rdy, we, re, dw, input dr, irq);
    modport slave  (input adr, cs, rdy, we, re, dw, output dr, irq);
endinterface

// File: rtl/rv_timer.sv
// Memory-mapped 32-bit timer with prescaler, compare match flag and level interrupt.
module rv_timer #(
    parameter int          PRESC_W  = 16,
    parameter logic [31:0] CMP_INIT = 32'hffffffff
) (
    input  logic       clk,
    input  logic       reset,
    rv_timer_if.slave  bus
);
    logic [2:0]         r_ctrl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pc;
    logic [31:0]        r_count;
    logic [31:0]        r_cmp;
    logic               r_mf;
    logic [31:0]        r_dr;
    logic               r_irq;

    logic        w_wr, w_rd, w_en, w_ar, w_ie, w_tick, w_match, w_clr;
    logic [2:0]  w_sel;
    logic [31:0] w_cur, w_merged;
    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] i_old, input logic [31:0] i_new,
                                            input logic [3:0] i_be);
        logic [31:0] v;
        v = i_old;
        for (int b = 0; b < 4; b++)
            if (i_be[b]) v[8*b +: 8] = i_new[8*b +: 8];
        return v;
    endfunction

    assign w_wr     = bus.cs & bus.rdy & (bus.we != 4'b0000);
    assign w_rd     = bus.cs & bus.rdy & bus.re;
    assign w_sel    = bus.adr[4:2];
    assign w_en     = r_ctrl[0];
    assign w_ar     = r_ctrl[1];
    assign w_ie     = r_ctrl[2];
    assign w_tick   = w_en & (r_pc == r_presc);
    // Match looks at the count value before this tick's increment.
    assign w_match  = w_tick & (r_count == r_cmp);
    assign w_clr    = w_wr & (w_sel == 3'd4) & bus.we[0] & bus.dw[0];
    assign w_unused = &{1'b0, bus.adr[1:0]};

    always_comb begin
        w_cur = '0;
        case (w_sel)
            3'd0:    w_cur = {29'b0, r_ctrl};
            3'd1:    w_cur = {{(32-PRESC_W){1'b0}}, r_presc};
            3'd2:    w_cur = r_count;
            3'd3:    w_cur = r_cmp;
            3'd4:    w_cur = {31'b0, r_mf};
            default: w_cur = '0;
        endcase
    end

    // The read mux doubles as the old value for byte-lane merging.
    assign w_merged = f_merge(w_cur, bus.dw, bus.we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl  <= '0;
            r_presc <= '0;
            r_cmp   <= CMP_INIT;
        end else if (w_wr) begin
            case (w_sel)
                3'd0:    r_ctrl  <= w_merged[2:0];
                3'd1:    r_presc <= w_merged[PRESC_W-1:0];
                3'd3:    r_cmp   <= w_merged;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pc <= '0;
        else if (!w_en || w_tick || (w_wr && w_sel == 3'd1))
            r_pc <= '0;
        else
            r_pc <= r_pc + PRESC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (w_wr && w_sel == 3'd2)
            r_count <= w_merged;
        else if (w_tick)
            r_count <= (w_match && w_ar) ? 32'd0 : r_count + 32'd1;
    end

    // A match in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_mf <= 1'b0;
        else if (w_match)
            r_mf <= 1'b1;
        else if (w_clr)
            r_mf <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dr  <= '0;
            r_irq <= 1'b0;
        end else begin
            r_dr  <= w_rd ? w_cur : 32'd0;
            r_irq <= r_mf & w_ie;
        end
    end

    assign bus.dr  = r_dr;
    assign bus.irq = r_irq;
endmodule

// File: tb/tb_rv_timer.sv
// Self-checking bench for rv_timer: register table, timing sequences and randomized traffic vs a model.
module tb_rv_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv_timer_if bus();

    rv_timer #(.PRESC_W(16), .CMP_INIT(32'hffffffff)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: CTRL, PRESC, COUNT, CMP, STAT held as plain words.
    logic [31:0] m_reg [5];
    logic [31:0] m_pc;
    logic [31:0] m_dr;
    logic        m_irq;

    typedef struct {
        string       name;
        logic [4:0]  adr;
        logic        cs;
        logic        rdy;
        logic [3:0]  we;
        logic        re;
        logic [31:0] dw;
        logic [31:0] exp_dr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_mask(input int idx);
        case (idx)
            0:       return 32'h0000_0007;
            1:       return 32'h0000_ffff;
            4:       return 32'h0000_0001;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    task automatic model_reset();
        m_reg[0] = 0;
        m_reg[1] = 0;
        m_reg[2] = 0;
        m_reg[3] = 32'hffffffff;
        m_reg[4] = 0;
        m_pc = 0;
        m_dr = 0;
        m_irq = 0;
    endtask

    task automatic model_step(input logic [4:0] a, input logic cs_, input logic rdy_,
                              input logic [3:0] we_, input logic re_, input logic [31:0] dw_);
        int sel;
        bit wr, rd, en, ar, ie, tick, match;
        logic [31:0] nxt [5];
        logic [31:0] tmp;
        sel   = int'(a[4:2]);
        wr    = cs_ && rdy_ && (we_ != 0);
        rd    = cs_ && rdy_ && re_;
        en    = m_reg[0][0];
        ar    = m_reg[0][1];
        ie    = m_reg[0][2];
        tick  = en && (m_pc == m_reg[1]);
        match = tick && (m_reg[2] == m_reg[3]);
        nxt   = m_reg;
        m_dr  = 0;
        if (rd && sel < 5) m_dr = m_reg[sel];
        m_irq = m_reg[4][0] & ie;
        if (tick) nxt[2] = (match && ar) ? 32'd0 : m_reg[2] + 32'd1;
        if (match) nxt[4] = 1;
        if (wr && sel < 4) begin
            tmp = m_reg[sel];
            for (int b = 0; b < 4; b++)
                if (we_[b]) tmp[8*b +: 8] = dw_[8*b +: 8];
            nxt[sel] = tmp & reg_mask(sel);
        end
        if (wr && sel == 4 && we_[0] && dw_[0] && !match) nxt[4] = 0;
        if (!en || (wr && sel == 1) || tick) m_pc = 0;
        else m_pc = m_pc + 1;
        m_reg = nxt;
    endtask

    task automatic cyc(input logic [4:0] a, input logic cs_, input logic rdy_,
                       input logic [3:0] we_, input logic re_, input logic [31:0] dw_);
        bus.adr = a;
        bus.cs  = cs_;
        bus.rdy = rdy_;
        bus.we  = we_;
        bus.re  = re_;
        bus.dw  = dw_;
        @(posedge clk);
        model_step(a, cs_, rdy_, we_, re_, dw_);
        #1;
        chk("dr_model", bus.dr, m_dr);
        chk("irq_model", {31'b0, bus.irq}, {31'b0, m_irq});
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(a, 1'b1, 1'b1, 4'hf, 1'b0, d);
    endtask

    task automatic rd(input logic [4:0] a);
        cyc(a, 1'b1, 1'b1, 4'h0, 1'b1, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic void add(input string nm, input logic [4:0] a, input logic cs_, input logic rdy_,
                                input logic [3:0] we_, input logic re_, input logic [31:0] dw_,
                                input logic [31:0] exp);
        vec_t v;
        v.name = nm; v.adr = a; v.cs = cs_; v.rdy = rdy_; v.we = we_; v.re = re_; v.dw = dw_;
        v.exp_dr = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        int t;
        logic [4:0] ra;
        int idx;
        logic [31:0] rdw;

        bus.adr = 0; bus.cs = 0; bus.rdy = 0; bus.we = 0; bus.re = 0; bus.dw = 0;
        do_reset();
        chk("reset_dr", bus.dr, 32'd0);
        chk("reset_irq", {31'b0, bus.irq}, 32'd0);
        rd(5'h08); chk("reset_count", bus.dr, 32'd0);
        rd(5'h0C); chk("reset_cmp", bus.dr, 32'hffffffff);

        // Register access with the timer disabled: results are fixed.
        add("cmp_wr",     5'h0C, 1, 1, 4'hf, 0, 32'h12345678, 32'h0);
        add("cmp_lane",   5'h0C, 1, 1, 4'h2, 0, 32'h0000ab00, 32'h0);
        add("cmp_rd",     5'h0C, 1, 1, 4'h0, 1, 32'h0,        32'h1234ab78);
        add("rsvd18_rd",  5'h18, 1, 1, 4'h0, 1, 32'h0,        32'h0);
        add("cs0_wr",     5'h0C, 0, 1, 4'hf, 0, 32'h0,        32'h0);
        add("rdy0_wr",    5'h0C, 1, 0, 4'hf, 0, 32'h0,        32'h0);
        add("cmp_rd2",    5'h0C, 1, 1, 4'h0, 1, 32'h0,        32'h1234ab78);
        add("rdy0_rd",    5'h0C, 1, 0, 4'h0, 1, 32'h0,        32'h0);
        add("presc_wr",   5'h04, 1, 1, 4'hf, 0, 32'hffffffff, 32'h0);
        add("presc_rd",   5'h04, 1, 1, 4'h0, 1, 32'h0,        32'h0000ffff);
        add("presc_lane", 5'h05, 1, 1, 4'h1, 0, 32'h00000012, 32'h0);
        add("presc_rd2",  5'h04, 1, 1, 4'h0, 1, 32'h0,        32'h0000ff12);
        add("ctrl_wr",    5'h00, 1, 1, 4'hf, 0, 32'h000000fa, 32'h0);
        add("ctrl_rd",    5'h00, 1, 1, 4'h0, 1, 32'h0,        32'h00000002);
        add("cnt_wr",     5'h08, 1, 1, 4'hf, 0, 32'hdeadbeef, 32'h0);
        add("cnt_rd",     5'h08, 1, 1, 4'h0, 1, 32'h0,        32'hdeadbeef);
        add("rsvd1c_wr",  5'h1C, 1, 1, 4'hf, 0, 32'hffffffff, 32'h0);
        add("rsvd1c_rd",  5'h1C, 1, 1, 4'h0, 1, 32'h0,        32'h0);
        add("stat_rd",    5'h10, 1, 1, 4'h0, 1, 32'h0,        32'h0);
        add("wr_rd_same", 5'h0C, 1, 1, 4'hf, 1, 32'h0,        32'h1234ab78);
        add("cmp_rd3",    5'h0C, 1, 1, 4'h0, 1, 32'h0,        32'h0);
        foreach (tbl[i]) begin
            cyc(tbl[i].adr, tbl[i].cs, tbl[i].rdy, tbl[i].we, tbl[i].re, tbl[i].dw);
            chk(tbl[i].name, bus.dr, tbl[i].exp_dr);
        end

        // Wrap past ffffffff without a flag until the compare value is reached.
        do_reset();
        wr(5'h0C, 32'd10);
        wr(5'h08, 32'hfffffffe);
        wr(5'h00, 32'd1);
        idle(1);
        rd(5'h08); chk("wrap_ffffffff", bus.dr, 32'hffffffff);
        rd(5'h08); chk("wrap_zero", bus.dr, 32'h0);
        rd(5'h10); chk("wrap_no_mf", bus.dr, 32'h0);
        idle(9);
        rd(5'h10); chk("wrap_mf_at10", bus.dr, 32'h1);

        // COUNT write landing on a tick: value held, next tick PRESC+1 clocks later.
        do_reset();
        wr(5'h04, 32'd3);
        wr(5'h00, 32'd1);
        idle(3);
        wr(5'h08, 32'd50);
        idle(2);
        rd(5'h08); chk("cw_hold1", bus.dr, 32'd50);
        rd(5'h08); chk("cw_hold2", bus.dr, 32'd50);
        rd(5'h08); chk("cw_next_tick", bus.dr, 32'd51);

        // One-shot: count keeps running after the match; W1C timing and W1C racing a match.
        do_reset();
        wr(5'h0C, 32'd2);
        wr(5'h00, 32'd5);
        idle(3);
        chk("os_irq_pre", {31'b0, bus.irq}, 32'd0);
        idle(1);
        chk("os_irq_set", {31'b0, bus.irq}, 32'd1);
        rd(5'h08); chk("os_count_cont", bus.dr, 32'd4);
        wr(5'h10, 32'd1);
        chk("os_w1c_irq_hold", {31'b0, bus.irq}, 32'd1);
        idle(1);
        chk("os_w1c_irq_low", {31'b0, bus.irq}, 32'd0);
        wr(5'h0C, 32'd103);
        wr(5'h08, 32'd100);
        idle(3);
        wr(5'h10, 32'd1);
        rd(5'h10); chk("os_w1c_vs_match", bus.dr, 32'd1);

        // Periodic auto-reload with PRESC=3, CMP=5: match every 24 clocks.
        do_reset();
        wr(5'h04, 32'd3);
        wr(5'h0C, 32'd5);
        wr(5'h00, 32'd7);
        t = 0;
        while (bus.irq !== 1'b1 && t < 40) begin idle(1); t++; end
        chk("ar_irq_latency", t, 32'd25);
        wr(5'h10, 32'd1); t++;
        idle(1); t++;
        chk("ar_irq_cleared", {31'b0, bus.irq}, 32'd0);
        while (bus.irq !== 1'b1 && t < 80) begin idle(1); t++; end
        chk("ar_irq_period", t, 32'd49);
        rd(5'h08);
        #2 reset = 1'b1;
        #1;
        chk("midrst_dr", bus.dr, 32'd0);
        chk("midrst_irq", {31'b0, bus.irq}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rd(5'h08); chk("midrst_count", bus.dr, 32'd0);
        rd(5'h0C); chk("midrst_cmp", bus.dr, 32'hffffffff);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            idx = $urandom_range(0, 7);
            ra  = {idx[2:0], 2'($urandom_range(0, 3))};
            case (idx)
                0:       rdw = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1 | 32'($urandom_range(0, 7));
                1:       rdw = 32'($urandom_range(0, 3));
                2:       rdw = ($urandom_range(0, 7) == 0) ? 32'hfffffff0 + 32'($urandom_range(0, 15))
                                                           : 32'($urandom_range(0, 40));
                3:       rdw = 32'($urandom_range(0, 40));
                default: rdw = $urandom;
            endcase
            cyc(ra, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                1'($urandom_range(0, 1)), rdw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
